// File: rtl/alu_pkg.sv
// Shared definitions for the sequential non-restoring divider: FSM state
// encoding and result constants used by the top-level control.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Quotient reported on divide-by-zero; users slice the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUOT = '1;

    // Most negative two's-complement value of the given width (width <= 64).
    function automatic logic [63:0] signed_min(input int unsigned width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division step on the partial remainder A
// (WIDTH+1 bits, two's complement) and the quotient/dividend shift register Q.
module nr_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] a_sh;

    // Shift {A,Q} left, subtract or add the divisor by the sign of the old A,
    // and retire the new quotient bit into Q[0].
    always_comb begin
        a_sh = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        if (a_in[WIDTH]) begin
            a_out = a_sh + m;
        end else begin
            a_out = a_sh - m;
        end
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle signed/unsigned non-restoring divider with start/done
// handshake. BITS_PER_CYCLE steps are chained per ITER cycle; the FSM,
// iteration counter and sign fixup live here.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(signed_min(WIDTH));
    localparam logic [WIDTH-1:0] QUOT_DBZ = DIV_ZERO_QUOT[WIDTH-1:0];

    state_e           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;       // partial remainder A
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend in, quotient out (Q)
    logic [WIDTH:0]   m_q, m_d;           // divisor magnitude M
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             op_zero;
    logic             op_ovf;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem_mag;

    logic [WIDTH:0]   a_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] q_chain [BITS_PER_CYCLE+1];

    assign a_chain[0] = acc_q;
    assign q_chain[0] = quo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        nr_div_step #(.WIDTH(WIDTH)) u_step (
            .a_in  (a_chain[i]),
            .q_in  (q_chain[i]),
            .m     (m_q),
            .a_out (a_chain[i+1]),
            .q_out (q_chain[i+1])
        );
    end

    // Operand classification for the accept cycle.
    always_comb begin
        accept  = start && (state_q == IDLE || state_q == DONE);
        op_zero = (divisor == '0);
        op_ovf  = is_signed && (dividend == MIN_VAL) && (divisor == '1);
        dvd_neg = is_signed && dividend[WIDTH-1];
        dvs_neg = is_signed && divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor  : divisor;
        rem_mag = acc_q[WIDTH] ? (acc_q[WIDTH-1:0] + m_q[WIDTH-1:0])
                               : acc_q[WIDTH-1:0];
    end

    // State and datapath registers; clr_n has priority over any start.
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            quo_q       <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic: special operands short-circuit straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (op_zero || op_ovf) ? DONE : ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER:    state_d = (cnt_q == CNT_W'(1)) ? FIX : ITER;
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand load, iteration, and final sign fixup.
    // NOTE: every _d gets a hold default first so no path infers a latch.
    always_comb begin
        acc_d       = acc_q;
        quo_d       = quo_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        if (accept) begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (op_zero) begin
                dbz_d       = 1'b1;
                quotient_d  = QUOT_DBZ;
                remainder_d = dividend;
            end else if (op_ovf) begin
                ovf_d       = 1'b1;
                quotient_d  = MIN_VAL;
                remainder_d = '0;
            end else begin
                acc_d     = '0;
                quo_d     = dvd_mag;
                m_d       = {1'b0, dvs_mag};
                cnt_d     = CNT_W'(ITERS);
                neg_quo_d = dvd_neg ^ dvs_neg;
                neg_rem_d = dvd_neg;
            end
        end else if (state_q == ITER) begin
            acc_d = a_chain[BITS_PER_CYCLE];
            quo_d = q_chain[BITS_PER_CYCLE];
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == FIX) begin
            quotient_d  = neg_quo_q ? -quo_q   : quo_q;
            remainder_d = neg_rem_q ? -rem_mag : rem_mag;
        end
    end

    // Handshake outputs decode from state; results come straight from flops.
    always_comb begin
        busy        = (state_q == ITER) || (state_q == FIX);
        done        = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: the stimulus side pushes the expected
// result and done cycle computed with plain integer arithmetic; a monitor
// pops and compares whenever done is seen.
module tb_alu_div_seq;

    localparam int W   = 32;
    localparam int BPC = 1;
    localparam int N   = W / BPC;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    alu_div_seq #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int unsigned  done_cyc;
        int unsigned  busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: integer division truncating toward zero, remainder with the
    // dividend's sign; special operands finish one cycle after accept.
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int unsigned acc_cyc);
        exp_t   e;
        longint sa;
        longint sb;
        longint min_val;
        min_val = -(longint'(1) << (W - 1));
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (sb == 0) begin
            e.dbz = 1'b1;
            e.q   = '1;
            e.r   = a;
        end else if (sgn && sa == min_val && sb == -1) begin
            e.ovf = 1'b1;
            e.q   = W'(min_val);
            e.r   = '0;
        end else begin
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end
        if (e.dbz || e.ovf) begin
            e.done_cyc    = acc_cyc + 1;
            e.busy_cycles = 0;
        end else begin
            e.done_cyc    = acc_cyc + N + 2;
            e.busy_cycles = N + 1;
        end
        return e;
    endfunction

    // Wait for busy low, present one operation, return just after the accept
    // edge. With hold set, start stays high for a back-to-back request.
    task automatic issue(input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles, expected 0", waited);
            return;
        end
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        exp_q.push_back(model(sgn, a, b, cyc));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},      64'(busy),        64'd0);
        check({tag, "_done"},      64'(done),        64'd0);
        check({tag, "_quotient"},  64'(quotient),    64'd0);
        check({tag, "_remainder"}, 64'(remainder),   64'd0);
        check({tag, "_dbz"},       64'(div_by_zero), 64'd0);
        check({tag, "_ovf"},       64'(overflow),    64'd0);
    endtask

    // Monitor: compare every done against the oldest expectation, including
    // the exact done cycle and the length of the preceding busy window.
    int unsigned busy_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no result pending", cyc);
            end else begin
                e = exp_q.pop_front();
                check("quotient",    64'(quotient),    64'(e.q));
                check("remainder",   64'(remainder),   64'(e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("overflow",    64'(overflow),    64'(e.ovf));
                check("done_cycle",  64'(cyc),         64'(e.done_cyc));
                check("busy_cycles", 64'(busy_cnt),    64'(e.busy_cycles));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        int           waited;

        clr_n     = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        repeat (3) @(negedge clk);
        // start held during reset must not launch anything
        check_cleared("reset");
        start = 1'b0;
        clr_n = 1'b1;

        // Directed operations
        issue(1'b0, 32'd100,        32'd7,        1'b0);
        issue(1'b1, 32'hFFFFFF9C,   32'd7,        1'b0);
        issue(1'b1, 32'd100,        32'hFFFFFFF9, 1'b0);
        issue(1'b0, 32'hFFFFFF9C,   32'd7,        1'b0);
        issue(1'b0, 32'd5,          32'd0,        1'b0);
        issue(1'b1, 32'h80000000,   32'hFFFFFFFF, 1'b0);
        issue(1'b0, 32'h80000000,   32'hFFFFFFFF, 1'b0);
        issue(1'b1, 32'hFFFFFFFB,   32'd0,        1'b0);
        issue(1'b1, 32'h80000000,   32'd1,        1'b0);
        issue(1'b0, 32'd3,          32'd10,       1'b0);
        issue(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 1'b0);

        // start pulsed mid-operation with new operands is ignored
        issue(1'b0, 32'd1000, 32'd9, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'd12;
        divisor  = 32'd5;

        // start held high through done: back-to-back accept in DONE cycle
        issue(1'b0, 32'd500,        32'd3, 1'b1);
        issue(1'b1, 32'hFFFFFE0C,   32'd3, 1'b0);

        // reset in the middle of ITER aborts the operation
        issue(1'b0, 32'd123456, 32'd11, 1'b0);
        repeat (9) @(negedge clk);
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check_cleared("abort");
        clr_n = 1'b1;
        issue(1'b1, 32'hFFFE1DC0, 32'd13, 1'b0);

        // Random regression with biased operand classes
        for (int i = 0; i < 1400; i++) begin
            sgn = 1'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h80000000; b = '1; end
                2: b = W'($urandom_range(1, 15));
                3: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(1, 300)); end
                4: b = -W'($urandom_range(1, 15));
                default: ;
            endcase
            issue(sgn, a, b, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain outstanding results
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
